skewed_fifo_bank: RTL and testbench

//   Bank of NUM_CH single-clock FIFOs that buffers feature/weight bytes for the systolic PE array.

---
 rtl/cnn_fifo_pkg.sv | 22 ++
 rtl/skewed_fifo_bank_sc_fifo.sv | 123 ++++++++++++
 rtl/skewed_fifo_bank.sv | 90 +++++++++
 tb/tb_skewed_fifo_bank.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_fifo_pkg.sv
// Shared constants and helpers for the skewed FIFO bank.
// Write/read mode encodings and a constant clog2.
package cnn_fifo_pkg;

  typedef enum logic {
    WR_BCAST = 1'b0,
    WR_ADDR  = 1'b1
  } wr_mode_e;

  typedef enum logic {
    RD_DIRECT = 1'b0,
    RD_SKEW   = 1'b1
  } rd_mode_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/skewed_fifo_bank_sc_fifo.sv
// One FIFO channel: RAM, pointers, occupancy, registered flags
// and sticky overflow/underflow bits.
module sc_fifo
  import cnn_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4096,
  parameter int LOG_DEPTH = 12,
  parameter int CNT_W     = 13,
  parameter int AF_LEVEL  = 4032
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [CNT_W-1:0]  count,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LEVEL);

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic                 af_q, af_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 pop_ok;
  logic                 push_ok;

  // A full channel still accepts a write when it pops in the same cycle.
  assign pop_ok  = rd_en && (cnt_q != '0);
  assign push_ok = wr_en && ((cnt_q != FULL_C) || pop_ok);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      rd_data_d = '0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
      if (pop_ok) begin
        rd_ptr_d   = rd_ptr_q + LOG_DEPTH'(1);
        rd_data_d  = mem[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      ovf_d = ovf_q | (wr_en & ~push_ok);
      udf_d = udf_q | (rd_en & ~pop_ok);
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == FULL_C);
    af_d    = (cnt_d >= AF_C);
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      af_q       <= af_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign count       = cnt_q;
  assign ovf_err     = ovf_q;
  assign udf_err     = udf_q;

endmodule

// File: rtl/skewed_fifo_bank.sv
// FIFO bank feeding the PE array: write-target decode, diagonal
// read skew, and one sc_fifo per PE row.
module skewed_fifo_bank
  import cnn_fifo_pkg::*;
#(
  parameter int NUM_CH    = 9,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4096,
  parameter int LOG_DEPTH = 12,
  parameter int CNT_W     = 13,
  parameter int AF_LEVEL  = 4032,
  parameter int CH_W      = clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     wr_mode,
  input  logic [NUM_CH-1:0]        wr_mask,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic                     wr_valid,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_skew,
  input  logic [NUM_CH-1:0]        rd_en,
  input  logic                     rd_go,
  output logic [NUM_CH*DATA_W-1:0] out_bus,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH-1:0]        empty,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        almost_full,
  output logic [NUM_CH*CNT_W-1:0]  count,
  output logic [NUM_CH-1:0]        ovf_err,
  output logic [NUM_CH-1:0]        udf_err
);

  logic [NUM_CH-1:0] wr_tgt;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:1] skew_q, skew_d;
  logic              skew_on;

  assign skew_on = (rd_skew == RD_SKEW);

  always_comb begin
    wr_tgt = '0;
    if (wr_mode == WR_ADDR) begin
      if (wr_valid && (int'(wr_ch) < NUM_CH)) wr_tgt[wr_ch] = 1'b1;
    end else begin
      wr_tgt = wr_mask & {NUM_CH{wr_valid}};
    end
  end

  // Bit j of the skew line is rd_go delayed j cycles; it runs freely
  // so a sweep drains even after rd_go drops.
  always_comb begin
    skew_d = {skew_q[NUM_CH-2:1], rd_go & skew_on};
    if (clear) skew_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) skew_q <= '0;
    else        skew_q <= skew_d;
  end

  assign pop = skew_on ? {skew_q, rd_go} : rd_en;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sc_fifo #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .LOG_DEPTH(LOG_DEPTH),
      .CNT_W    (CNT_W),
      .AF_LEVEL (AF_LEVEL)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .wr_en      (wr_tgt[g]),
      .rd_en      (pop[g]),
      .wr_data    (wr_data),
      .rd_data    (out_bus[g*DATA_W +: DATA_W]),
      .rd_valid   (out_valid[g]),
      .empty      (empty[g]),
      .full       (full[g]),
      .almost_full(almost_full[g]),
      .count      (count[g*CNT_W +: CNT_W]),
      .ovf_err    (ovf_err[g]),
      .udf_err    (udf_err[g])
    );
  end

endmodule

// File: tb/tb_skewed_fifo_bank.sv
// Scoreboard bench for skewed_fifo_bank with a queue-based reference
// model, directed scenarios and a randomized soak.
module tb_skewed_fifo_bank;

  localparam int NCH   = 9;
  localparam int DW    = 8;
  localparam int DEP   = 8;
  localparam int LDEP  = 3;
  localparam int CW    = 4;
  localparam int AFL   = 6;
  localparam int CHW   = 4;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              wr_mode;
  logic [NCH-1:0]    wr_mask;
  logic [CHW-1:0]    wr_ch;
  logic              wr_valid;
  logic [DW-1:0]     wr_data;
  logic              rd_skew;
  logic [NCH-1:0]    rd_en;
  logic              rd_go;
  logic [NCH*DW-1:0] out_bus;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    empty;
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    almost_full;
  logic [NCH*CW-1:0] count;
  logic [NCH-1:0]    ovf_err;
  logic [NCH-1:0]    udf_err;

  skewed_fifo_bank #(
    .NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP),
    .LOG_DEPTH(LDEP), .CNT_W(CW), .AF_LEVEL(AFL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_mode(wr_mode), .wr_mask(wr_mask), .wr_ch(wr_ch),
    .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_skew(rd_skew), .rd_en(rd_en), .rd_go(rd_go),
    .out_bus(out_bus), .out_valid(out_valid),
    .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string nm, input int ch,
                     input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s ch%0d: got 0x%0h expected 0x%0h",
                  nm, ch, act, exp);
  endtask

  // Reference model: one queue of stored bytes per channel.
  logic [DW-1:0] mq  [NCH][$];
  logic [DW-1:0] exq [NCH][$];
  logic [DW-1:0] last [NCH];
  logic          mov [NCH];
  logic          mud [NCH];
  int            gos [$];
  int            cyc = 0;

  function automatic void m_reset();
    for (int i = 0; i < NCH; i++) begin
      mq[i].delete();
      exq[i].delete();
      last[i] = '0;
      mov[i]  = 1'b0;
      mud[i]  = 1'b0;
    end
    gos.delete();
  endfunction

  function automatic bit go_at(input int c);
    foreach (gos[k]) if (gos[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : mdl
    logic [NCH-1:0] tgt;
    logic [NCH-1:0] p;
    if (!rst_n || clear) begin
      m_reset();
    end else begin
      tgt = '0;
      if (wr_mode == 1'b0) tgt = wr_mask & {NCH{wr_valid}};
      else if (wr_valid && int'(wr_ch) < NCH) tgt[wr_ch] = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (rd_skew) p[i] = (i == 0) ? rd_go : go_at(cyc - i);
        else         p[i] = rd_en[i];
      end
      if (rd_skew && rd_go) gos.push_back(cyc);
      while (gos.size() > 0 && gos[0] < cyc - NCH) void'(gos.pop_front());
      for (int i = 0; i < NCH; i++) begin
        if (p[i]) begin
          if (mq[i].size() > 0) exq[i].push_back(mq[i].pop_front());
          else mud[i] = 1'b1;
        end
        if (tgt[i]) begin
          if (mq[i].size() < DEP) mq[i].push_back(wr_data);
          else mov[i] = 1'b1;
        end
      end
    end
    cyc++;
  end

  always @(posedge clk) begin : mon
    logic [8:0] st_a;
    logic [8:0] st_e;
    int n;
    #1;
    for (int i = 0; i < NCH; i++) begin
      chk("out_valid", i, int'(out_valid[i]), int'(exq[i].size() > 0));
      if (exq[i].size() > 0) last[i] = exq[i].pop_front();
      chk("out_bus", i, int'(out_bus[i*DW +: DW]), int'(last[i]));
      n = mq[i].size();
      st_e = {CW'(n), n == 0, n == DEP, n >= AFL, mov[i], mud[i]};
      st_a = {count[i*CW +: CW], empty[i], full[i], almost_full[i],
              ovf_err[i], udf_err[i]};
      chk("status", i, int'(st_a), int'(st_e));
    end
  end

  function automatic int cnt_of(input int i);
    return int'(count[i*CW +: CW]);
  endfunction

  function automatic int byte_of(input int i);
    return int'(out_bus[i*DW +: DW]);
  endfunction

  task automatic idle();
    clear = 0; wr_mode = 0; wr_mask = '0; wr_ch = '0;
    wr_valid = 0; wr_data = '0; rd_skew = 0; rd_en = '0; rd_go = 0;
  endtask

  task automatic wr_addr(input int ch, input int d);
    wr_mode = 1; wr_ch = CHW'(ch); wr_valid = 1; wr_data = DW'(d);
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    // 1: traffic then asynchronous reset between edges
    wr_mask = '1; wr_valid = 1;
    for (int k = 0; k < 3; k++) begin
      wr_data = DW'($urandom);
      @(negedge clk);
    end
    idle(); rd_en = '1;
    @(negedge clk);
    idle();
    #2 rst_n = 0;
    #1;
    chk("rst_empty", 0, int'(empty), 'h1FF);
    chk("rst_count", 0, int'(count), 0);
    chk("rst_valid", 0, int'(out_valid), 0);
    chk("rst_err", 0, int'({ovf_err, udf_err}), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // 2: broadcast write then direct reads
    wr_mode = 0; wr_mask = 9'h0A5; wr_valid = 1;
    for (int k = 0; k < 4; k++) begin
      wr_data = DW'(8'h11 + k);
      @(negedge clk);
    end
    idle();
    chk("bc_cnt", 0, cnt_of(0), 4);
    chk("bc_cnt", 1, cnt_of(1), 0);
    chk("bc_cnt", 7, cnt_of(7), 4);
    chk("bc_empty", 0, int'(empty), 'h15A);
    for (int k = 0; k < 4; k++) begin
      rd_en = 9'h0A5;
      @(negedge clk);
      chk("bc_data", 2, byte_of(2), 'h11 + k);
    end
    idle();

    // 3: skewed sweep over one entry per channel
    for (int i = 0; i < NCH; i++) begin
      wr_addr(i, 'h20 + i);
      @(negedge clk);
    end
    idle();
    rd_skew = 1; rd_go = 1;
    @(negedge clk);
    rd_go = 0;
    for (int k = 0; k < NCH; k++) begin
      if (k > 0) @(negedge clk);
      chk("skew_valid", k, int'(out_valid), 1 << k);
      chk("skew_data", k, byte_of(k), 'h20 + k);
    end
    @(negedge clk);
    chk("skew_done", 0, int'(out_valid), 0);
    idle();

    // 4: overfill channel 3, then write with pop while full
    for (int k = 0; k < DEP + 1; k++) begin
      wr_addr(3, 'h30 + k);
      @(negedge clk);
    end
    idle();
    chk("full", 3, int'(full[3]), 1);
    chk("ovf", 3, int'(ovf_err[3]), 1);
    chk("af", 3, int'(almost_full[3]), 1);
    chk("full_cnt", 3, cnt_of(3), DEP);
    for (int k = 0; k < 2; k++) begin
      wr_addr(3, 'h40 + k); rd_en = 9'h008;
      @(negedge clk);
      chk("fwp_data", 3, byte_of(3), 'h30 + k);
      chk("fwp_cnt", 3, cnt_of(3), DEP);
    end
    idle(); rd_en = 9'h008;
    repeat (DEP) @(negedge clk);
    idle();

    // 5: pop an empty channel, then pop with same-cycle write
    rd_en = 9'h002;
    @(negedge clk);
    chk("udf_valid", 1, int'(out_valid[1]), 0);
    chk("udf", 1, int'(udf_err[1]), 1);
    wr_addr(1, 'h55);
    @(negedge clk);
    chk("udf_wr_cnt", 1, cnt_of(1), 1);
    chk("udf_wr_valid", 1, int'(out_valid[1]), 0);
    idle(); rd_en = 9'h002;
    @(negedge clk);
    chk("udf_rd", 1, byte_of(1), 'h55);
    idle();

    // 6a: pointer wrap on channel 4
    wr_addr(4, 'h60);
    @(negedge clk);
    for (int k = 0; k < 3 * DEP; k++) begin
      wr_addr(4, 'h61 + k); rd_en = 9'h010;
      @(negedge clk);
      chk("wrap_data", 4, byte_of(4), 'h60 + k);
    end
    idle(); rd_en = 9'h010;
    @(negedge clk);
    idle();

    // 6b: clear in the middle of a skewed sweep
    wr_mode = 0; wr_mask = '1; wr_valid = 1;
    for (int k = 0; k < 2; k++) begin
      wr_data = DW'('h70 + k);
      @(negedge clk);
    end
    idle(); rd_skew = 1; rd_go = 1;
    @(negedge clk);
    rd_go = 0;
    repeat (2) @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk("clr_count", 0, int'(count), 0);
    for (int k = 0; k < NCH; k++) begin
      chk("clr_valid", k, int'(out_valid), 0);
      @(negedge clk);
    end
    idle();

    // 7: randomized soak
    for (int k = 0; k < 3000; k++) begin
      clear    = ($urandom_range(0, 99) == 0);
      wr_mode  = 1'($urandom);
      wr_mask  = NCH'($urandom);
      wr_ch    = CHW'($urandom_range(0, 12));
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = DW'($urandom);
      if ($urandom_range(0, 39) == 0) rd_skew = ~rd_skew;
      rd_en    = NCH'($urandom);
      rd_go    = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    idle();
    repeat (NCH + 2) @(negedge clk);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
